// File: rtl/apb_cmd_master.sv
// APB initiator: executes single read/write transfers from a packed host command
// stream and returns a status header (plus read data) for each command.
module apb_cmd_master #(
  parameter int ADDR_W  = 40,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       cmd_data,
  input  logic              cmd_empty,
  output logic              cmd_rd_en,
  output logic [31:0]       rsp_data,
  output logic              rsp_wr_en,
  input  logic              rsp_full,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [31:0]       pwdata,
  output logic [3:0]        pstrb,
  input  logic [31:0]       prdata,
  input  logic              pready,
  input  logic              pslverr,
  output logic              busy,
  output logic [15:0]       err_count
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_GET_DATA = 3'd1,
    ST_SETUP    = 3'd2,
    ST_ACCESS   = 3'd3,
    ST_RSP_HDR  = 3'd4,
    ST_RSP_DATA = 3'd5
  } state_t;

  localparam logic [1:0] STS_OK      = 2'b00;
  localparam logic [1:0] STS_SLVERR  = 2'b01;
  localparam logic [1:0] STS_TIMEOUT = 2'b10;
  localparam logic [7:0] TO_LAST     = 8'(TIMEOUT - 1);

  state_t      state_r;
  state_t      state_s;
  logic        cmd_rd_s;
  logic        rsp_wr_s;
  logic        acc_done_s;
  logic        acc_tmo_s;
  logic [1:0]  sts_s;
  logic        write_r;
  logic [6:0]  tag_r;
  logic [7:0]  wait_cnt_r;
  logic [31:0] rdata_r;
  logic [31:0] rsp_data_r;
  logic        psel_r;
  logic        penable_r;
  logic        pwrite_r;
  logic [ADDR_W-1:0] paddr_r;
  logic [31:0] pwdata_r;
  logic [3:0]  pstrb_r;
  logic        busy_r;
  logic [15:0] err_count_r;
  logic        unused_s;

  function automatic logic [31:0] build_hdr(input logic [1:0] sts, input logic wr,
                                            input logic [6:0] tag);
    build_hdr = {sts, wr, tag, 22'h0};
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] cnt);
    if (cnt == 16'hFFFF) begin
      sat_inc = cnt;
    end else begin
      sat_inc = cnt + 16'd1;
    end
  endfunction

  assign unused_s = ^cmd_data[1:0];

  // Next-state decode and FIFO handshake requests.
  always_comb begin
    state_s    = state_r;
    cmd_rd_s   = 1'b0;
    rsp_wr_s   = 1'b0;
    acc_done_s = 1'b0;
    acc_tmo_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (!cmd_empty) begin
          cmd_rd_s = 1'b1;
          state_s  = cmd_data[31] ? ST_GET_DATA : ST_SETUP;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_GET_DATA: begin
        if (!cmd_empty) begin
          cmd_rd_s = 1'b1;
          state_s  = ST_SETUP;
        end else begin
          state_s = ST_GET_DATA;
        end
      end
      ST_SETUP: begin
        state_s = ST_ACCESS;
      end
      ST_ACCESS: begin
        // pready wins over the timeout on the last allowed cycle
        if (pready) begin
          acc_done_s = 1'b1;
          state_s    = ST_RSP_HDR;
        end else if (wait_cnt_r == TO_LAST) begin
          acc_tmo_s = 1'b1;
          state_s   = ST_RSP_HDR;
        end else begin
          state_s = ST_ACCESS;
        end
      end
      ST_RSP_HDR: begin
        if (!rsp_full) begin
          rsp_wr_s = 1'b1;
          state_s  = write_r ? ST_IDLE : ST_RSP_DATA;
        end else begin
          state_s = ST_RSP_HDR;
        end
      end
      ST_RSP_DATA: begin
        if (!rsp_full) begin
          rsp_wr_s = 1'b1;
          state_s  = ST_IDLE;
        end else begin
          state_s = ST_RSP_DATA;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Completion status of the current access cycle.
  always_comb begin
    sts_s = STS_TIMEOUT;
    if (acc_done_s) begin
      sts_s = pslverr ? STS_SLVERR : STS_OK;
    end else begin
      sts_s = STS_TIMEOUT;
    end
  end

  // State, APB outputs, response data and error counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      write_r     <= 1'b0;
      tag_r       <= 7'h0;
      wait_cnt_r  <= 8'h0;
      rdata_r     <= 32'h0;
      rsp_data_r  <= 32'h0;
      psel_r      <= 1'b0;
      penable_r   <= 1'b0;
      pwrite_r    <= 1'b0;
      paddr_r     <= '0;
      pwdata_r    <= 32'h0;
      pstrb_r     <= 4'h0;
      busy_r      <= 1'b0;
      err_count_r <= 16'h0;
    end else begin
      state_r   <= state_s;
      psel_r    <= (state_s == ST_SETUP) || (state_s == ST_ACCESS);
      penable_r <= (state_s == ST_ACCESS);
      busy_r    <= (state_s != ST_IDLE);
      case (state_r)
        ST_IDLE: begin
          if (cmd_rd_s) begin
            write_r  <= cmd_data[31];
            tag_r    <= cmd_data[30:24];
            pwrite_r <= cmd_data[31];
            paddr_r  <= {{(ADDR_W-24){1'b0}}, cmd_data[23:2], 2'b00};
            pstrb_r  <= cmd_data[31] ? 4'hF : 4'h0;
            pwdata_r <= 32'h0;
          end
        end
        ST_GET_DATA: begin
          if (cmd_rd_s) begin
            pwdata_r <= cmd_data;
          end
        end
        ST_SETUP: begin
          wait_cnt_r <= 8'h0;
        end
        ST_ACCESS: begin
          if (acc_done_s || acc_tmo_s) begin
            rsp_data_r <= build_hdr(sts_s, write_r, tag_r);
            rdata_r    <= (acc_done_s && !write_r) ? prdata : 32'h0;
            if (sts_s != STS_OK) begin
              err_count_r <= sat_inc(err_count_r);
            end
          end else begin
            wait_cnt_r <= wait_cnt_r + 8'd1;
          end
        end
        ST_RSP_HDR: begin
          if (rsp_wr_s && !write_r) begin
            rsp_data_r <= rdata_r;
          end
        end
        default: ;
      endcase
    end
  end

  assign cmd_rd_en = cmd_rd_s & ~reset;
  assign rsp_wr_en = rsp_wr_s & ~reset;
  assign rsp_data  = rsp_data_r;
  assign psel      = psel_r;
  assign penable   = penable_r;
  assign pwrite    = pwrite_r;
  assign paddr     = paddr_r;
  assign pwdata    = pwdata_r;
  assign pstrb     = pstrb_r;
  assign busy      = busy_r;
  assign err_count = err_count_r;

endmodule
